// File: rtl/hw3proc_timer_pkg.sv
// Shared register-map constants and write-strobe decode for the multi-channel interval timer.
package hw3proc_timer_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_SNAP     = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;
  localparam logic [2:0] OFF_COMPARE  = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
    logic prescale;
    logic compare;
  } wr_strobe_t;

  function automatic wr_strobe_t decode_write(input logic wr_en, input logic [2:0] offset);
    wr_strobe_t s;
    s          = '0;
    s.status   = wr_en && (offset == OFF_STATUS);
    s.control  = wr_en && (offset == OFF_CONTROL);
    s.period   = wr_en && (offset == OFF_PERIOD);
    s.snap     = wr_en && (offset == OFF_SNAP);
    s.prescale = wr_en && (offset == OFF_PRESCALE);
    s.compare  = wr_en && (offset == OFF_COMPARE);
    return s;
  endfunction

endpackage

// File: rtl/hw3proc_timer_channel.sv
// One timer channel: prescaled down-counter with reload, one-shot/continuous modes,
// snapshot capture, timeout flag/irq and registered PWM compare output.
module hw3proc_timer_channel
  import hw3proc_timer_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset,
  input  wr_strobe_t  wr,
  input  logic [31:0] writedata,
  input  logic [2:0]  rd_offset,
  output logic [31:0] rd_value,
  output logic        irq,
  output logic        pwm
);

  localparam logic [CNT_W-1:0] DEF_CNT = CNT_W'(DEF_PERIOD);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] compare;
  logic [CNT_W-1:0] snapshot;
  logic [15:0]      prescale;
  logic [15:0]      psc_cnt;
  logic             cont;
  logic             ito;
  logic             run;
  logic             to;
  logic             reload_pending;
  logic             tick;
  logic             timeout;

  // The forced reload cycle owns the counter, so no tick is taken while it is pending.
  assign tick    = run && (psc_cnt == prescale) && !reload_pending;
  assign timeout = tick && (counter == '0);
  assign irq     = to && ito;

  // NOTE: every register here is updated with <= so later statements in the block
  // can override earlier ones (write strobes beat tick effects) without ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter        <= DEF_CNT;
      period         <= DEF_CNT;
      compare        <= '0;
      snapshot       <= '0;
      prescale       <= '0;
      psc_cnt        <= '0;
      cont           <= 1'b0;
      ito            <= 1'b0;
      run            <= 1'b0;
      to             <= 1'b0;
      reload_pending <= 1'b0;
      pwm            <= 1'b0;
    end else begin
      if (tick) begin
        psc_cnt <= '0;
        if (counter == '0) begin
          counter <= period;
          if (!cont) run <= 1'b0;
        end else begin
          counter <= counter - CNT_W'(1);
        end
      end else if (run) begin
        psc_cnt <= psc_cnt + 16'd1;
      end

      if (reload_pending) begin
        counter <= period;
        psc_cnt <= '0;
        run     <= 1'b0;
      end
      reload_pending <= wr.period;

      if (wr.period)   period   <= writedata[CNT_W-1:0];
      if (wr.prescale) prescale <= writedata[15:0];
      if (wr.compare)  compare  <= writedata[CNT_W-1:0];
      if (wr.snap)     snapshot <= counter;

      if (wr.status)       to <= 1'b0;
      else if (timeout)    to <= 1'b1;

      // START is applied last so it wins over STOP, reload and one-shot expiry.
      if (wr.control) begin
        ito  <= writedata[CTRL_ITO];
        cont <= writedata[CTRL_CONT];
        if (writedata[CTRL_STOP]) run <= 1'b0;
        if (writedata[CTRL_START]) begin
          run     <= 1'b1;
          psc_cnt <= '0;
        end
      end

      pwm <= run && (counter < compare);
    end
  end

  // NOTE: rd_value gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    rd_value = '0;
    case (rd_offset)
      OFF_STATUS: begin
        rd_value[STAT_TO]  = to;
        rd_value[STAT_RUN] = run;
      end
      OFF_CONTROL: begin
        rd_value[CTRL_ITO]  = ito;
        rd_value[CTRL_CONT] = cont;
      end
      OFF_PERIOD:   rd_value[CNT_W-1:0] = period;
      OFF_SNAP:     rd_value[CNT_W-1:0] = snapshot;
      OFF_PRESCALE: rd_value[15:0]      = prescale;
      OFF_COMPARE:  rd_value[CNT_W-1:0] = compare;
      default:      rd_value = '0;
    endcase
  end

endmodule

// File: rtl/hw3proc_multi_timer.sv
// Multi-channel interval timer, Avalon-MM slave: address decode, channel array,
// registered read mux and combined interrupt.
module hw3proc_multi_timer
  import hw3proc_timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 49999,
  parameter int ADDR_W     = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any,
  output logic [NUM_CH-1:0] pwm
);

  logic [ADDR_W-1:0] ch_sel;
  logic [2:0]        offset;
  logic              wr_en;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       rd_next;

  // Channel field may be empty when NUM_CH == 1; the shift keeps that case legal.
  assign ch_sel  = address >> 3;
  assign offset  = address[2:0];
  assign wr_en   = chipselect && !write_n;
  assign irq_any = |irq;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wr_strobe_t wr;
    assign wr = decode_write(wr_en && (ch_sel == ADDR_W'(i)), offset);

    hw3proc_timer_channel #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr        (wr),
      .writedata (writedata),
      .rd_offset (offset),
      .rd_value  (ch_rdata[i]),
      .irq       (irq[i]),
      .pwm       (pwm[i])
    );
  end

  // Unpopulated channel indices fall through and read as zero.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ADDR_W'(i)) rd_next = ch_rdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

endmodule
